sti_dac_gen: RTL and testbench
==============================

Name: sti_dac_gen

Overview:
Parametrised successor of the serial-transmit / data-arrange pair. It accepts one parallel word per handshake and emits it as a framed, fill-padded serial stream of 1..MAX_BYTES bytes. It reassembles the stream into bytes and scatters them over BANKS memory pairs (odd/even) in a checkerboard pattern. On end-of-stream it zero-fills the remaining capacity and then signals finish.

Parameters:
DATA_W, 16, width of pi_data (multiple of 8, >=8)
MAX_BYTES, 4, maximum frame length in bytes (power of 2)
BANKS, 4, number of odd/even memory pairs
ADDR_W, 5, address width per memory
ROW_BIT, 2, address bit whose value inverts odd/even parity (checkerboard)
GAP, 3, idle cycles between frames (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
load  in  1  word valid; accepted when load && pi_ready
pi_ready  out  1  high only in IDLE
pi_data  in  DATA_W  parallel word
pi_length  in  $clog2(MAX_BYTES)  frame length minus one, in bytes; L = 8*(pi_length+1)
pi_fill  in  1  1: data in MSBs, zero padding below; 0: zero padding above
pi_msb  in  1  1: frame bit L-1 sent first
pi_low  in  1  when L<DATA_W: 1 selects the upper L bits of pi_data, 0 the lower L bits
pi_end  in  1  sampled with the word; marks it as the last word
so_data  out  1  serial bit
so_valid  out  1  high for exactly L cycles per frame
oem_dataout  out  8  write data
oem_addr  out  ADDR_W  write address
oem_wr_odd  out  BANKS  one-hot write strobe, odd memories
oem_wr_even  out  BANKS  one-hot write strobe, even memories
oem_finish  out  1  sticky; all capacity written

Behaviour:
- Clock is clk. Reset is synchronous and active-high. All outputs reset to 0 except pi_ready, which resets to 1. Internal state returns to IDLE with byte index n=0.
- A reset asserted mid-frame or mid-fill aborts the operation. No write strobe is issued in the cycle after reset.
- All pi_* inputs are captured into registers on acceptance. Input changes after acceptance have no effect.
- Frame construction, L<DATA_W: the frame is the selected L-bit slice (see pi_low).
- Frame construction, L>=DATA_W: pi_fill=1 gives frame = {pi_data, zeros}; pi_fill=0 gives frame = {zeros, pi_data}.
- Transmit FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE -> SHIFT on acceptance.
- SHIFT lasts L cycles. so_valid=1, and so_data is the registered frame bit (MSB- or LSB-first). so_valid rises 1 cycle after acceptance.
- SHIFT -> GAP after the last bit. GAP lasts GAP cycles with so_valid=0.
- GAP -> DONE if the captured end flag is set, else GAP -> IDLE.
- DONE is terminal until reset.
- Byte assembly: the first received bit of each byte is bit 7. A completed byte gets byte index n.
- Address mapping: bank = n >> (ADDR_W+1); k = n mod 2^(ADDR_W+1); addr = k>>1; parity = k[0] ^ addr[ROW_BIT].
- parity 0 pulses oem_wr_odd[bank]; parity 1 pulses oem_wr_even[bank].
- Each strobe is a one-cycle pulse with oem_dataout and oem_addr valid in the same cycle. The strobe occurs 2 cycles after the so_valid cycle carrying the byte's last bit. n then increments.
- Capacity C = BANKS*2^(ADDR_W+1). Bytes arriving at n>=C are dropped with no strobe.
- Zero-fill: on entering DONE with n<C, write 0x00 to every remaining index, one strobe every 2 cycles.
- oem_finish rises 1 cycle after the strobe for n=C-1 and stays high until reset. If n==C on entering DONE, it rises 1 cycle after entering DONE.
- All strobes are 0 when no write is in progress. Odd and even strobes are never high simultaneously.

Decomposition:
- Shared package: FSM state enum, the L computation function, and the byte-index-to-{bank, addr, parity} mapping function, so the bench uses the same mapping model as the RTL.
- One sub-module, sti_dac_gen_arrange: byte assembly, address mapping, zero-fill, and finish.
- The top module holds the transmit FSM and serialiser.

Test Plan:
- DATA_W=16. pi_data=16'hA5C3, pi_length=0, pi_low=1, pi_msb=1 -> so_data 1,0,1,0,0,1,0,1 over 8 valid cycles. oem_wr_odd[0] pulse, addr 0, data 0xA5.
- Same word with pi_length=3, pi_fill=1, pi_msb=1 -> bytes A5, C3, 00, 00 land at odd0@0, even0@0, odd0@1, even0@1.
- pi_length=3, pi_fill=0, pi_msb=0, pi_data=16'h0001 -> first so_data bit is 1, then 31 zeros. The first byte written is 0x80.
- Write bytes 8..15 of bank 0 (addr 4..7) -> parity inverted: even strobes come first at each address.
- pi_end on the first word of 1 byte -> zero-fill writes C-1 bytes of 0x00 at 2-cycle spacing. oem_finish rises 1 cycle after the last strobe and stays high. A further load is not accepted (pi_ready=0).
- Reset asserted mid-SHIFT -> next cycle so_valid=0, pi_ready=1, strobes 0. A new frame then writes at n=0.

Source files
------------

// File: rtl/sti_dac_gen_pkg.sv
// Shared types and helpers for the serial transmit / data arrange pipeline:
// FSM state encoding, frame length and byte-index to memory location mapping.
package sti_dac_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } tx_state_e;

  typedef struct packed {
    logic [15:0] bank;
    logic [15:0] addr;
    logic        parity;  // 0: odd memory, 1: even memory
  } byte_loc_t;

  // Frame length in bits for a length-minus-one byte count.
  function automatic int unsigned frame_bits(input int unsigned len_m1);
    return 8 * (len_m1 + 1);
  endfunction

  // Checkerboard scatter: address bit row_bit flips which memory of the pair
  // receives the even/odd byte of each address.
  function automatic byte_loc_t map_index(input int unsigned n,
                                          input int unsigned addr_w,
                                          input int unsigned row_bit);
    int unsigned k;
    int unsigned row;
    byte_loc_t   loc;
    k          = n & ((32'd1 << (addr_w + 1)) - 32'd1);
    row        = k >> (row_bit + 1);
    loc.bank   = 16'(n >> (addr_w + 1));
    loc.addr   = 16'(k >> 1);
    loc.parity = k[0] ^ row[0];
    return loc;
  endfunction

endpackage

// File: rtl/sti_dac_gen_arrange.sv
// Reassembles the serial stream into bytes, scatters them over the odd/even
// memory pairs, zero-fills the remaining capacity at end of stream, flags finish.
module sti_dac_gen_arrange
  import sti_dac_gen_pkg::*;
#(
  parameter int BANKS   = 4,
  parameter int ADDR_W  = 5,
  parameter int ROW_BIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_i,
  input  logic              valid_i,
  input  logic              done_i,
  output logic [7:0]        dataout_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [BANKS-1:0]  wr_odd_o,
  output logic [BANKS-1:0]  wr_even_o,
  output logic              finish_o
);

  localparam int CAP = BANKS * (2 ** (ADDR_W + 1));
  localparam int N_W = $clog2(CAP + 1);
  localparam logic [N_W-1:0] CAP_C = N_W'(CAP);

  logic [7:0]        sh_q, sh_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic              byte_vld_q, byte_vld_d;
  logic [N_W-1:0]    n_q, n_d;
  logic              phase_q, phase_d;
  logic              finish_q, finish_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BANKS-1:0]  odd_q, odd_d;
  logic [BANKS-1:0]  even_q, even_d;
  logic              full;
  logic              do_wr;
  logic [7:0]        wr_byte;
  byte_loc_t         loc;

  assign full = (n_q == CAP_C);
  assign loc  = map_index(32'(n_q), ADDR_W, ROW_BIT);

  always_comb begin
    sh_d       = sh_q;
    bcnt_d     = bcnt_q;
    byte_vld_d = 1'b0;
    n_d        = n_q;
    phase_d    = 1'b0;
    data_d     = '0;
    addr_d     = '0;
    odd_d      = '0;
    even_d     = '0;
    do_wr      = 1'b0;
    wr_byte    = '0;

    // First received bit of a byte ends up in bit 7.
    if (valid_i) begin
      sh_d       = {sh_q[6:0], bit_i};
      bcnt_d     = bcnt_q + 3'd1;
      byte_vld_d = (bcnt_q == 3'd7);
    end

    // Zero-fill alternates write / idle so strobes land every other cycle.
    if (byte_vld_q) begin
      do_wr   = !full;
      wr_byte = sh_q;
    end else if (done_i && !phase_q) begin
      do_wr   = !full;
      phase_d = !full;
    end

    if (do_wr) begin
      n_d    = n_q + N_W'(1);
      data_d = wr_byte;
      addr_d = ADDR_W'(loc.addr);
      if (loc.parity) even_d = BANKS'(1) << loc.bank;
      else            odd_d  = BANKS'(1) << loc.bank;
    end

    finish_d = finish_q | (full & done_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q       <= '0;
      bcnt_q     <= '0;
      byte_vld_q <= 1'b0;
      n_q        <= '0;
      phase_q    <= 1'b0;
      finish_q   <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      odd_q      <= '0;
      even_q     <= '0;
    end else begin
      sh_q       <= sh_d;
      bcnt_q     <= bcnt_d;
      byte_vld_q <= byte_vld_d;
      n_q        <= n_d;
      phase_q    <= phase_d;
      finish_q   <= finish_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      odd_q      <= odd_d;
      even_q     <= even_d;
    end
  end

  assign dataout_o = data_q;
  assign addr_o    = addr_q;
  assign wr_odd_o  = odd_q;
  assign wr_even_o = even_q;
  assign finish_o  = finish_q;

endmodule

// File: rtl/sti_dac_gen.sv
// Parallel-to-serial frame transmitter (IDLE/SHIFT/GAP/DONE) feeding the
// byte arranger that scatters the stream over odd/even memory pairs.
module sti_dac_gen
  import sti_dac_gen_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MAX_BYTES = 4,
  parameter int BANKS     = 4,
  parameter int ADDR_W    = 5,
  parameter int ROW_BIT   = 2,
  parameter int GAP       = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  output logic                         pi_ready,
  input  logic [DATA_W-1:0]            pi_data,
  input  logic [$clog2(MAX_BYTES)-1:0] pi_length,
  input  logic                         pi_fill,
  input  logic                         pi_msb,
  input  logic                         pi_low,
  input  logic                         pi_end,
  output logic                         so_data,
  output logic                         so_valid,
  output logic [7:0]                   oem_dataout,
  output logic [ADDR_W-1:0]            oem_addr,
  output logic [BANKS-1:0]             oem_wr_odd,
  output logic [BANKS-1:0]             oem_wr_even,
  output logic                         oem_finish
);

  localparam int FW    = (DATA_W > 8 * MAX_BYTES) ? DATA_W : 8 * MAX_BYTES;
  localparam int CNT_W = $clog2(FW + 1);
  localparam int GAP_W = $clog2(GAP + 1);
  localparam logic [CNT_W-1:0] DATA_W_C = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] FW_C     = CNT_W'(FW);

  tx_state_e        state_q, state_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [FW-1:0]    frame_new;
  logic [FW-1:0]    data_ext;
  logic             msb_q, msb_d;
  logic             end_q, end_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_bits;
  logic [GAP_W-1:0] gap_q, gap_d;

  assign data_ext = FW'(pi_data);
  assign len_bits = CNT_W'(frame_bits(32'(pi_length)));

  // The frame is built in bits [L-1:0]; MSB-first frames are then left-aligned
  // so the serialiser always reads a fixed end of the shift register.
  always_comb begin
    frame_new = data_ext;
    if (len_bits < DATA_W_C) begin
      if (pi_low) frame_new = data_ext >> (DATA_W_C - len_bits);
      else        frame_new = data_ext & ~({FW{1'b1}} << len_bits);
    end else if (pi_fill) begin
      frame_new = data_ext << (len_bits - DATA_W_C);
    end
    if (pi_msb) frame_new = frame_new << (FW_C - len_bits);
  end

  // NOTE: every signal this block drives gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    msb_d   = msb_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_SHIFT;
          frame_d = frame_new;
          msb_d   = pi_msb;
          end_d   = pi_end;
          cnt_d   = len_bits - CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        frame_d = msb_q ? (frame_q << 1) : (frame_q >> 1);
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          gap_d   = GAP_W'(GAP - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = end_q ? ST_DONE : ST_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      msb_q   <= 1'b0;
      end_q   <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      msb_q   <= msb_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign pi_ready = (state_q == ST_IDLE);
  assign so_valid = (state_q == ST_SHIFT);
  assign so_data  = so_valid & (msb_q ? frame_q[FW-1] : frame_q[0]);

  sti_dac_gen_arrange #(
    .BANKS   (BANKS),
    .ADDR_W  (ADDR_W),
    .ROW_BIT (ROW_BIT)
  ) u_arrange (
    .clk       (clk),
    .reset     (reset),
    .bit_i     (so_data),
    .valid_i   (so_valid),
    .done_i    (state_q == ST_DONE),
    .dataout_o (oem_dataout),
    .addr_o    (oem_addr),
    .wr_odd_o  (oem_wr_odd),
    .wr_even_o (oem_wr_even),
    .finish_o  (oem_finish)
  );

endmodule

// File: tb/tb_sti_dac_gen.sv
// Directed bench for sti_dac_gen: serial bits checked inline, memory writes
// checked against a scoreboard filled when each word is driven.
module tb_sti_dac_gen;
  import sti_dac_gen_pkg::*;

  localparam int DATA_W    = 16;
  localparam int MAX_BYTES = 4;
  localparam int BANKS     = 4;
  localparam int ADDR_W    = 5;
  localparam int ROW_BIT   = 2;
  localparam int GAP       = 3;
  localparam int CAP       = BANKS * (2 ** (ADDR_W + 1));

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b0;
  logic [15:0]       pi_data = '0;
  logic [1:0]        pi_length = '0;
  logic              pi_fill = 1'b0, pi_msb = 1'b0, pi_low = 1'b0, pi_end = 1'b0;
  logic              pi_ready, so_data, so_valid, oem_finish;
  logic [7:0]        oem_dataout;
  logic [ADDR_W-1:0] oem_addr;
  logic [BANKS-1:0]  oem_wr_odd, oem_wr_even;

  sti_dac_gen #(
    .DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES), .BANKS(BANKS),
    .ADDR_W(ADDR_W), .ROW_BIT(ROW_BIT), .GAP(GAP)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .pi_ready(pi_ready),
    .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
    .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .so_data(so_data), .so_valid(so_valid), .oem_dataout(oem_dataout),
    .oem_addr(oem_addr), .oem_wr_odd(oem_wr_odd), .oem_wr_even(oem_wr_even),
    .oem_finish(oem_finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BANKS-1:0]  odd;
    logic [BANKS-1:0]  even;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                cyc;
  } wr_t;

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  n_exp = 0;
  int  rx_bits = 0;
  int  last_wr_cyc = -100;
  bit  last_was_fill = 1'b0;
  wr_t sb[$];
  wr_t wlog[$];
  int  due_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every strobe and checks latency/spacing.
  always @(negedge clk) begin
    wr_t got;
    wr_t ex;
    bit  is_fill;
    if (!reset) begin
      if (so_valid) begin
        rx_bits++;
        if (rx_bits % 8 == 0) due_q.push_back(cyc + 2);
      end
      if ((oem_wr_odd | oem_wr_even) != '0) begin
        got = '{oem_wr_odd, oem_wr_even, oem_addr, oem_dataout, cyc};
        check("strobe_onehot", 32'($onehot({oem_wr_odd, oem_wr_even})), 32'd1);
        if (sb.size() == 0) begin
          check("unexpected_write", 32'(sb.size()), 32'd1);
        end else begin
          ex = sb.pop_front();
          check("wr_odd", 32'(got.odd), 32'(ex.odd));
          check("wr_even", 32'(got.even), 32'(ex.even));
          check("wr_addr", 32'(got.addr), 32'(ex.addr));
          check("wr_data", 32'(got.data), 32'(ex.data));
        end
        is_fill = (due_q.size() == 0);
        if (!is_fill) check("strobe_latency", cyc, due_q.pop_front());
        else if (last_was_fill) check("fill_spacing", cyc - last_wr_cyc, 32'd2);
        last_was_fill = is_fill;
        last_wr_cyc   = cyc;
        wlog.push_back(got);
      end
    end
  end

  function automatic logic [31:0] model_frame(input logic [15:0] d, input int len_b,
                                               input bit fill, input bit low);
    if (len_b < 16) return low ? {24'h0, d[15:8]} : {24'h0, d[7:0]};
    if (fill) return {d, 16'h0} >> (32 - len_b);
    return {16'h0, d};
  endfunction

  task automatic push_exp(input logic [7:0] by);
    byte_loc_t loc;
    wr_t       e;
    if (n_exp < CAP) begin
      loc    = map_index(n_exp, ADDR_W, ROW_BIT);
      e.odd  = loc.parity ? '0 : (BANKS'(1) << loc.bank);
      e.even = loc.parity ? (BANKS'(1) << loc.bank) : '0;
      e.addr = ADDR_W'(loc.addr);
      e.data = by;
      e.cyc  = 0;
      sb.push_back(e);
    end
    n_exp++;
  endtask

  task automatic send_word(input logic [15:0] d, input logic [1:0] len, input bit fill,
                           input bit msb, input bit low, input bit endf);
    int          len_b;
    int          w;
    logic [31:0] f;
    logic [31:0] t;
    logic [7:0]  by;
    len_b = 8 * (int'(len) + 1);
    f     = model_frame(d, len_b, fill, low);
    for (int b = 0; b < len_b / 8; b++) begin
      by = '0;
      for (int j = 0; j < 8; j++) begin
        t  = msb ? (f >> (len_b - 1 - (b * 8 + j))) : (f >> (b * 8 + j));
        by = {by[6:0], t[0]};
      end
      push_exp(by);
    end
    if (endf) while (n_exp < CAP) push_exp(8'h00);
    @(posedge clk); #1;
    w = 0;
    while (!pi_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_before_load", 32'(pi_ready), 32'd1);
    pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low; pi_end = endf;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    pi_data = ~d; pi_length = ~len; pi_fill = !fill; pi_msb = !msb; pi_low = !low; pi_end = !endf;
    for (int i = 0; i < len_b; i++) begin
      @(negedge clk);
      t = msb ? (f >> (len_b - 1 - i)) : (f >> i);
      check("so_valid", 32'(so_valid), 32'd1);
      check("so_data", 32'(so_data), 32'(t[0]));
    end
    @(negedge clk);
    check("so_valid_after", 32'(so_valid), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete(); wlog.delete(); due_q.delete();
    rx_bits = 0; n_exp = 0; last_was_fill = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; load = 1'b0;
    @(posedge clk);
    release_reset();
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pi_ready", 32'(pi_ready), 32'd1);
    check("rst_so_valid", 32'(so_valid), 32'd0);
    check("rst_so_data", 32'(so_data), 32'd0);
    check("rst_strobes", 32'({oem_wr_odd, oem_wr_even}), 32'd0);
    check("rst_data_addr", 32'({oem_dataout, oem_addr}), 32'd0);
    check("rst_finish", 32'(oem_finish), 32'd0);
    release_reset();

    // Single byte, upper slice, MSB first
    send_word(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();
    check("t1_count", 32'(wlog.size()), 32'd1);
    check("t1_odd", 32'(wlog[0].odd), 32'd1);
    check("t1_addr", 32'(wlog[0].addr), 32'd0);
    check("t1_data", 32'(wlog[0].data), 32'hA5);

    // Four bytes, data in MSBs
    do_reset();
    send_word(16'hA5C3, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    check("t2_count", 32'(wlog.size()), 32'd4);
    check("t2_d0", 32'(wlog[0].data), 32'hA5);
    check("t2_d1", 32'(wlog[1].data), 32'hC3);
    check("t2_d2", 32'(wlog[2].data), 32'h00);
    for (int k = 0; k < 4; k++) begin
      check("t2_odd", 32'(wlog[k].odd), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("t2_even", 32'(wlog[k].even), (k % 2 == 1) ? 32'd1 : 32'd0);
      check("t2_addr", 32'(wlog[k].addr), 32'(k / 2));
    end

    // LSB first, data in LSBs
    do_reset();
    send_word(16'h0001, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    check("t3_data", 32'(wlog[0].data), 32'h80);
    check("t3_odd", 32'(wlog[0].odd), 32'd1);

    // Continue to n=17, crossing the inverted-parity rows at addr 4..7
    send_word(16'h1234, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(16'hBEEF, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(16'h5A3C, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(16'h00C1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(16'hF00F, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();
    check("t4_count", 32'(wlog.size()), 32'd18);
    check("t4_n8_even", 32'(wlog[8].even), 32'd1);
    check("t4_n8_addr", 32'(wlog[8].addr), 32'd4);
    check("t4_n9_odd", 32'(wlog[9].odd), 32'd1);
    check("t4_n10_data", 32'(wlog[10].data), 32'hF7);
    check("t4_n11_data", 32'(wlog[11].data), 32'h7D);
    check("t4_n14_data", 32'(wlog[14].data), 32'h83);
    check("t4_n15_odd", 32'(wlog[15].odd), 32'd1);
    check("t4_n15_addr", 32'(wlog[15].addr), 32'd7);

    // End on the first word: zero-fill the rest, then finish
    do_reset();
    send_word(16'h3C00, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    w = 0;
    while (!oem_finish && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("finish_seen", 32'(oem_finish), 32'd1);
    check("finish_timing", cyc, last_wr_cyc + 1);
    check("fill_count", 32'(wlog.size()), 32'(CAP));
    check("fill_sb_empty", 32'(sb.size()), 32'd0);
    check("fill_first", 32'(wlog[0].data), 32'h3C);
    check("fill_last_odd", 32'(wlog[CAP-1].odd), 32'b1000);
    check("fill_last_addr", 32'(wlog[CAP-1].addr), 32'd31);
    @(posedge clk); #1;
    load = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("done_ready", 32'(pi_ready), 32'd0);
      check("done_valid", 32'(so_valid), 32'd0);
      check("done_finish", 32'(oem_finish), 32'd1);
    end
    @(posedge clk); #1;
    load = 1'b0;

    // Reset clears finish; then abort a frame just before its first strobe
    do_reset();
    @(negedge clk);
    check("rst_finish_clr", 32'(oem_finish), 32'd0);
    @(posedge clk); #1;
    pi_data = 16'hFFFF; pi_length = 2'd3; pi_fill = 1'b0; pi_msb = 1'b1; pi_end = 1'b0;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_valid", 32'(so_valid), 32'd0);
    check("abort_ready", 32'(pi_ready), 32'd1);
    check("abort_strobes", 32'({oem_wr_odd, oem_wr_even}), 32'd0);
    release_reset();
    send_word(16'h7E00, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();
    check("abort_count", 32'(wlog.size()), 32'd1);
    check("abort_odd", 32'(wlog[0].odd), 32'd1);
    check("abort_addr", 32'(wlog[0].addr), 32'd0);
    check("abort_data", 32'(wlog[0].data), 32'h7E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
